// File: rtl/blit_pkg.sv
// Shared types, widths and helpers for the blitter memory arbiter.
package blit_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_RD_REQ, ARB_RD_DATA, ARB_WR_REQ} blit_arb_state_t;

  localparam int BLIT_ADDR_W = 26;
  localparam int BLIT_DATA_W = 32;
  localparam int BLIT_BE_W   = 4;
  localparam logic [3:0] BLIT_STREAK_SAT = 4'd15;

  function automatic logic [3:0] streak_inc(input logic [3:0] v);
    return (v == BLIT_STREAK_SAT) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/blit_mem_arbiter.sv
// Arbitrates the blitter read and write stages onto one SDRAM master port.
// Optional performance counters are enabled by defining BLIT_ARB_PERF_EN.
module blit_mem_arbiter
  import blit_pkg::*;
#(
  parameter int MAX_READ_STREAK = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   blitr_req,
  input  logic [BLIT_ADDR_W-1:0] blitr_addr,
  output logic                   blitr_ack,
  output logic [BLIT_DATA_W-1:0] blitr_rdata,
  output logic                   blitr_rdvalid,
  output logic                   blitr_complete,
  input  logic                   blitw_req,
  input  logic [BLIT_ADDR_W-1:0] blitw_addr,
  input  logic [BLIT_DATA_W-1:0] blitw_wdata,
  input  logic [BLIT_BE_W-1:0]   blitw_byte_enable,
  input  logic                   blitw_urgent,
  output logic                   blitw_ack,
  output logic                   sdram_req,
  output logic                   sdram_write,
  output logic [BLIT_ADDR_W-1:0] sdram_addr,
  output logic [BLIT_DATA_W-1:0] sdram_wdata,
  output logic [BLIT_BE_W-1:0]   sdram_byte_enable,
  input  logic                   sdram_ack,
  input  logic [BLIT_DATA_W-1:0] sdram_rdata,
  input  logic                   sdram_rdvalid,
  input  logic                   sdram_complete,
`ifdef BLIT_ARB_PERF_EN
  output logic [31:0]            perf_rd_grants,
  output logic [31:0]            perf_wr_grants,
  output logic [31:0]            perf_wait_cycles,
`endif
  output logic                   arb_busy
);

  localparam logic [3:0] MAX_STREAK_C = 4'(MAX_READ_STREAK);

  blit_arb_state_t        state_q, state_d;
  logic [3:0]             streak_q, streak_d;
  logic [BLIT_ADDR_W-1:0] addr_q, addr_d;
  logic [BLIT_DATA_W-1:0] wdata_q, wdata_d;
  logic [BLIT_BE_W-1:0]   be_q, be_d;
  logic                   write_wins;

  assign write_wins = blitw_req && (blitw_urgent || !blitr_req || (streak_q >= MAX_STREAK_C));

  // Next-state, grant latching and handshake outputs; acks are suppressed while reset is held.
  always_comb begin
    state_d        = state_q;
    streak_d       = streak_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    be_d           = be_q;
    blitr_ack      = 1'b0;
    blitw_ack      = 1'b0;
    blitr_rdvalid  = 1'b0;
    blitr_complete = 1'b0;
    sdram_req      = 1'b0;
    sdram_write    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (write_wins) begin
          state_d  = ARB_WR_REQ;
          addr_d   = blitw_addr;
          wdata_d  = blitw_wdata;
          be_d     = blitw_byte_enable;
          streak_d = 4'd0;
        end else if (blitr_req) begin
          state_d  = ARB_RD_REQ;
          addr_d   = blitr_addr;
          wdata_d  = {BLIT_DATA_W{1'b0}};
          be_d     = 4'hF;
          streak_d = blitw_req ? streak_inc(streak_q) : 4'd0;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_RD_REQ: begin
        sdram_req = 1'b1;
        if (sdram_ack) begin
          blitr_ack = blitr_req && !reset;
          state_d   = ARB_RD_DATA;
        end else begin
          state_d = ARB_RD_REQ;
        end
      end
      ARB_RD_DATA: begin
        blitr_rdvalid  = sdram_rdvalid && !reset;
        blitr_complete = sdram_complete && !reset;
        if (sdram_complete) begin
          state_d = ARB_IDLE;
        end else begin
          state_d = ARB_RD_DATA;
        end
      end
      ARB_WR_REQ: begin
        sdram_req   = 1'b1;
        sdram_write = 1'b1;
        if (sdram_ack) begin
          blitw_ack = blitw_req && !reset;
          state_d   = ARB_IDLE;
        end else begin
          state_d = ARB_WR_REQ;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State, streak and latched transaction registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      streak_q <= 4'd0;
      addr_q   <= {BLIT_ADDR_W{1'b0}};
      wdata_q  <= {BLIT_DATA_W{1'b0}};
      be_q     <= {BLIT_BE_W{1'b0}};
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
    end
  end

  assign sdram_addr        = addr_q;
  assign sdram_wdata       = wdata_q;
  assign sdram_byte_enable = be_q;
  assign blitr_rdata       = sdram_rdata;
  assign arb_busy          = (state_q != ARB_IDLE);

`ifdef BLIT_ARB_PERF_EN
  logic [31:0] perf_rd_q, perf_rd_d, perf_wr_q, perf_wr_d, perf_wait_q, perf_wait_d;

  // Wait cycles: something is requesting but nothing is accepted (idle, or downstream not acking).
  always_comb begin
    perf_rd_d   = perf_rd_q;
    perf_wr_d   = perf_wr_q;
    perf_wait_d = perf_wait_q;
    if ((state_q == ARB_IDLE) && (state_d == ARB_RD_REQ)) begin
      perf_rd_d = perf_rd_q + 32'd1;
    end else if ((state_q == ARB_IDLE) && (state_d == ARB_WR_REQ)) begin
      perf_wr_d = perf_wr_q + 32'd1;
    end else begin
      perf_rd_d = perf_rd_q;
    end
    if ((blitr_req || blitw_req) && ((state_q == ARB_IDLE) || (sdram_req && !sdram_ack))) begin
      perf_wait_d = perf_wait_q + 32'd1;
    end else begin
      perf_wait_d = perf_wait_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_rd_q   <= 32'd0;
      perf_wr_q   <= 32'd0;
      perf_wait_q <= 32'd0;
    end else begin
      perf_rd_q   <= perf_rd_d;
      perf_wr_q   <= perf_wr_d;
      perf_wait_q <= perf_wait_d;
    end
  end

  assign perf_rd_grants   = perf_rd_q;
  assign perf_wr_grants   = perf_wr_q;
  assign perf_wait_cycles = perf_wait_q;
`endif

endmodule

// File: tb/tb_blit_mem_arbiter.sv
// Self-checking bench: transaction-level reference model plus directed scenarios and random traffic.
module tb_blit_mem_arbiter;

  localparam int MAXS   = 4;
  localparam int K_NONE = 0;
  localparam int K_RD   = 1;
  localparam int K_WR   = 2;

  logic        clock, reset;
  logic        blitr_req, blitr_ack, blitr_rdvalid, blitr_complete;
  logic [25:0] blitr_addr;
  logic [31:0] blitr_rdata;
  logic        blitw_req, blitw_urgent, blitw_ack;
  logic [25:0] blitw_addr;
  logic [31:0] blitw_wdata;
  logic [3:0]  blitw_byte_enable;
  logic        sdram_req, sdram_write, sdram_ack, sdram_rdvalid, sdram_complete;
  logic [25:0] sdram_addr;
  logic [31:0] sdram_wdata, sdram_rdata;
  logic [3:0]  sdram_byte_enable;
  logic        arb_busy;

  blit_mem_arbiter #(.MAX_READ_STREAK(MAXS)) dut (
    .clock(clock), .reset(reset),
    .blitr_req(blitr_req), .blitr_addr(blitr_addr), .blitr_ack(blitr_ack),
    .blitr_rdata(blitr_rdata), .blitr_rdvalid(blitr_rdvalid), .blitr_complete(blitr_complete),
    .blitw_req(blitw_req), .blitw_addr(blitw_addr), .blitw_wdata(blitw_wdata),
    .blitw_byte_enable(blitw_byte_enable), .blitw_urgent(blitw_urgent), .blitw_ack(blitw_ack),
    .sdram_req(sdram_req), .sdram_write(sdram_write), .sdram_addr(sdram_addr),
    .sdram_wdata(sdram_wdata), .sdram_byte_enable(sdram_byte_enable), .sdram_ack(sdram_ack),
    .sdram_rdata(sdram_rdata), .sdram_rdvalid(sdram_rdvalid), .sdram_complete(sdram_complete),
    .arb_busy(arb_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the transaction in flight, not a state machine mirror.
  int          m_kind = K_NONE;
  bit          m_accepted = 1'b0;
  logic [25:0] m_addr = 26'd0;
  logic [31:0] m_wdata = 32'd0;
  logic [3:0]  m_be = 4'd0;
  int          m_reads_since_write = 0;

  logic e_rack, e_wack;
  logic s_rack, s_wack, s_rdvalid, s_req, s_write;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare every output against the model, advance the model, move to the next cycle.
  task automatic step();
    logic e_req, e_write, e_rdvalid, e_cmpl;
    bit   wr_win;
    #3;
    e_req     = ((m_kind == K_RD) && !m_accepted) || (m_kind == K_WR);
    e_write   = (m_kind == K_WR);
    e_rack    = !reset && (m_kind == K_RD) && !m_accepted && sdram_ack && blitr_req;
    e_wack    = !reset && (m_kind == K_WR) && sdram_ack && blitw_req;
    e_rdvalid = !reset && (m_kind == K_RD) && m_accepted && sdram_rdvalid;
    e_cmpl    = !reset && (m_kind == K_RD) && m_accepted && sdram_complete;
    s_rack = blitr_ack; s_wack = blitw_ack; s_rdvalid = blitr_rdvalid;
    s_req = sdram_req; s_write = sdram_write;
    chk("sdram_req", {31'd0, sdram_req}, {31'd0, e_req});
    chk("sdram_write", {31'd0, sdram_write}, {31'd0, e_write});
    chk("sdram_addr", {6'd0, sdram_addr}, {6'd0, m_addr});
    chk("sdram_wdata", sdram_wdata, m_wdata);
    chk("sdram_be", {28'd0, sdram_byte_enable}, {28'd0, m_be});
    chk("blitr_ack", {31'd0, blitr_ack}, {31'd0, e_rack});
    chk("blitw_ack", {31'd0, blitw_ack}, {31'd0, e_wack});
    chk("blitr_rdvalid", {31'd0, blitr_rdvalid}, {31'd0, e_rdvalid});
    chk("blitr_complete", {31'd0, blitr_complete}, {31'd0, e_cmpl});
    chk("blitr_rdata", blitr_rdata, sdram_rdata);
    chk("arb_busy", {31'd0, arb_busy}, {31'd0, (m_kind != K_NONE)});
    if (reset) begin
      m_kind = K_NONE; m_accepted = 1'b0; m_addr = 26'd0; m_wdata = 32'd0; m_be = 4'd0;
      m_reads_since_write = 0;
    end else if (m_kind == K_NONE) begin
      wr_win = blitw_req && (blitw_urgent || !blitr_req || (m_reads_since_write >= MAXS));
      if (wr_win) begin
        m_kind = K_WR; m_addr = blitw_addr; m_wdata = blitw_wdata; m_be = blitw_byte_enable;
        m_reads_since_write = 0;
      end else if (blitr_req) begin
        m_kind = K_RD; m_accepted = 1'b0; m_addr = blitr_addr; m_wdata = 32'd0; m_be = 4'hF;
        m_reads_since_write = blitw_req ? ((m_reads_since_write < 15) ? m_reads_since_write + 1 : 15) : 0;
      end
    end else if (m_kind == K_RD && !m_accepted) begin
      if (sdram_ack) m_accepted = 1'b1;
    end else if (m_kind == K_RD) begin
      if (sdram_complete) m_kind = K_NONE;
    end else begin
      if (sdram_ack) m_kind = K_NONE;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    blitr_req = 1'b0; blitr_addr = 26'd0; blitw_req = 1'b0; blitw_addr = 26'd0;
    blitw_wdata = 32'd0; blitw_byte_enable = 4'd0; blitw_urgent = 1'b0;
    sdram_ack = 1'b0; sdram_rdata = 32'd0; sdram_rdvalid = 1'b0; sdram_complete = 1'b0;
  endtask

  task automatic drain_to_idle(input string name);
    clear_inputs();
    sdram_ack = 1'b1; sdram_complete = 1'b1;
    for (int i = 0; i < 20 && arb_busy; i++) step();
    chk(name, {31'd0, arb_busy}, 32'd0);
    clear_inputs();
  endtask

  initial begin
    bit          r_on, w_on;
    logic [25:0] r_addr, w_addr;
    logic [31:0] w_data;
    logic [3:0]  w_be;
    int          nrv, ng;
    logic [9:0]  grants;
    logic [9:0]  exp_grants;

    clear_inputs();
    reset = 1'b1;
    @(posedge clock);
    #1;
    step();
    step();
    reset = 1'b0;
    chk("reset_busy", {31'd0, arb_busy}, 32'd0);
    chk("reset_req", {31'd0, sdram_req}, 32'd0);
    chk("reset_addr", {6'd0, sdram_addr}, 32'd0);

    // Read-only transaction with four beats.
    blitr_req = 1'b1; blitr_addr = 26'h000100;
    step();
    chk("t1_req_rise", {31'd0, sdram_req}, 32'd1);
    chk("t1_write", {31'd0, sdram_write}, 32'd0);
    chk("t1_addr", {6'd0, sdram_addr}, 32'h00000100);
    chk("t1_be", {28'd0, sdram_byte_enable}, 32'hF);
    step();
    sdram_ack = 1'b1;
    step();
    chk("t1_ack", {31'd0, s_rack}, 32'd1);
    blitr_req = 1'b0; sdram_ack = 1'b0;
    nrv = 0;
    for (int i = 0; i < 4; i++) begin
      sdram_rdvalid = 1'b1; sdram_rdata = 32'hA000_0000 + 32'(i);
      step();
      if (s_rdvalid) nrv++;
    end
    sdram_rdvalid = 1'b0; sdram_complete = 1'b1;
    step();
    sdram_complete = 1'b0;
    chk("t1_rdvalid_count", 32'(nrv), 32'd4);
    chk("t1_busy_drop", {31'd0, arb_busy}, 32'd0);

    // Write-only transaction.
    blitw_req = 1'b1; blitw_addr = 26'h0002A4; blitw_wdata = 32'hDEADBEEF; blitw_byte_enable = 4'b0110;
    step();
    chk("t2_write", {31'd0, sdram_write}, 32'd1);
    chk("t2_addr", {6'd0, sdram_addr}, 32'h000002A4);
    chk("t2_wdata", sdram_wdata, 32'hDEADBEEF);
    chk("t2_be", {28'd0, sdram_byte_enable}, 32'h6);
    sdram_ack = 1'b1;
    step();
    chk("t2_ack_with_sdram_ack", {30'd0, s_wack, s_req}, 32'h3);
    clear_inputs();
    step();

    // Both requesting continuously: streak limit interleaves writes.
    blitr_req = 1'b1; blitw_req = 1'b1; sdram_ack = 1'b1; sdram_complete = 1'b1;
    ng = 0; grants = 10'd0;
    for (int i = 0; i < 40 && ng < 10; i++) begin
      blitr_addr = 26'(i * 4); blitw_addr = 26'(26'h100000 + i * 4); blitw_wdata = 32'(i);
      step();
      if (s_req) begin
        grants[9 - ng] = s_write;
        ng++;
      end
    end
    exp_grants = 10'b0000100001;
    chk("t3_grant_count", 32'(ng), 32'd10);
    chk("t3_grant_seq", {22'd0, grants}, {22'd0, exp_grants});
    drain_to_idle("t3_drain");
    step();

    // Urgent write overrides a pending read.
    blitr_req = 1'b1; blitr_addr = 26'h000040; blitw_req = 1'b1; blitw_urgent = 1'b1;
    blitw_addr = 26'h000080; blitw_wdata = 32'h1234_5678; blitw_byte_enable = 4'hF;
    step();
    chk("t4_urgent_write", {30'd0, sdram_req, sdram_write}, 32'h3);
    drain_to_idle("t4_drain");

    // Reset during the read data phase abandons the transaction.
    blitr_req = 1'b1; blitr_addr = 26'h000200;
    step();
    sdram_ack = 1'b1;
    step();
    blitr_req = 1'b0; sdram_ack = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; sdram_rdvalid = 1'b1; sdram_complete = 1'b1;
    step();
    chk("t5_no_rdvalid", {31'd0, s_rdvalid}, 32'd0);
    chk("t5_no_ack", {31'd0, s_rack}, 32'd0);
    chk("t5_idle", {31'd0, arb_busy}, 32'd0);
    chk("t5_addr_zero", {6'd0, sdram_addr}, 32'd0);
    clear_inputs();

    // Stray downstream pulses while idle.
    sdram_ack = 1'b1; sdram_complete = 1'b1; sdram_rdvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_acks", {30'd0, s_rack, s_wack}, 32'd0);
    end
    chk("t6_idle", {31'd0, arb_busy}, 32'd0);
    clear_inputs();

    // Random traffic, including protocol violations and occasional resets.
    r_on = 1'b0; w_on = 1'b0; r_addr = 26'd0; w_addr = 26'd0; w_data = 32'd0; w_be = 4'd0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      if (!r_on && $urandom_range(0, 2) == 0) begin
        r_on = 1'b1; r_addr = 26'($urandom);
      end else if (r_on && $urandom_range(0, 149) == 0) begin
        r_on = 1'b0;
      end
      if (!w_on && $urandom_range(0, 2) == 0) begin
        w_on = 1'b1; w_addr = 26'($urandom); w_data = $urandom; w_be = 4'($urandom);
      end else if (w_on && $urandom_range(0, 149) == 0) begin
        w_on = 1'b0;
      end
      blitr_req = r_on; blitr_addr = r_addr;
      blitw_req = w_on; blitw_addr = w_addr; blitw_wdata = w_data; blitw_byte_enable = w_be;
      blitw_urgent = w_on && ($urandom_range(0, 7) == 0);
      sdram_ack = ($urandom_range(0, 2) == 0);
      sdram_rdvalid = 1'($urandom_range(0, 1));
      sdram_complete = ($urandom_range(0, 4) == 0);
      sdram_rdata = $urandom;
      step();
      if (e_rack) r_on = 1'b0;
      if (e_wack) w_on = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
